// File: rtl/conv_latency_monitor.sv
// rtl/conv_latency_monitor.sv - gamma-cycle convergence latency monitor for the L2 error
//
// Watches a stimulus for changes and counts gamma cycles until the observed
// error settles at or below TOL for HOLD consecutive samples, or until MAX_CYC
// cycles have passed. Each finished measurement is reported once and folded
// into running statistics.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   cycle_start_i  one-clock pulse at each gamma cycle boundary
//   en_i           measurement enable; low keeps the monitor idle
//   stim_in_i      observed stimulus (8 bit)
//   err_in_i       observed L2 error (8 bit)
//   busy_o         measurement (or report) in progress
//   lat_valid_o    one-clock pulse: lat_out_o / lat_timeout_o are new
//   lat_out_o      latency of the last report, in gamma cycles
//   lat_timeout_o  last report hit MAX_CYC without converging
//   trans_cnt_o    completed reports, saturating
//   abort_cnt_o    measurements restarted by a new transition, saturating
//   lat_sum_o      sum of reported latencies, saturating
//   lat_min_o      smallest reported latency (8'hFF before the first report)
//   lat_max_o      largest reported latency
module conv_latency_monitor #(
    parameter logic [7:0] TOL     = 8'd5,
    parameter logic [7:0] HOLD    = 8'd1,
    parameter logic [7:0] MAX_CYC = 8'd10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cycle_start_i,
    input  logic        en_i,
    input  logic [7:0]  stim_in_i,
    input  logic [7:0]  err_in_i,
    output logic        busy_o,
    output logic        lat_valid_o,
    output logic [7:0]  lat_out_o,
    output logic        lat_timeout_o,
    output logic [7:0]  trans_cnt_o,
    output logic [7:0]  abort_cnt_o,
    output logic [15:0] lat_sum_o,
    output logic [7:0]  lat_min_o,
    output logic [7:0]  lat_max_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    // A HOLD of zero would report before any sample is seen; treat it as one.
    localparam logic [8:0] HOLD_EFF = (HOLD == 8'd0) ? 9'd1 : {1'b0, HOLD};

    state_t      state_q;
    logic [7:0]  stim_q;
    logic        primed_q;
    logic [7:0]  cnt_q;
    logic [7:0]  run_q;
    logic        busy_q;
    logic        lat_valid_q;
    logic [7:0]  lat_out_q;
    logic        lat_timeout_q;
    logic [7:0]  trans_cnt_q;
    logic [7:0]  abort_cnt_q;
    logic [15:0] lat_sum_q;
    logic [7:0]  lat_min_q;
    logic [7:0]  lat_max_q;

    logic        event_d;
    logic [7:0]  cnt_d;
    logic [8:0]  run_d;
    logic        converged_d;
    logic        report_d;
    logic [7:0]  rep_lat_d;
    logic        rep_to_d;
    logic [16:0] sum_ext_d;
    logic [15:0] lat_sum_d;

    always_comb begin
        event_d     = 1'b0;
        cnt_d       = 8'd0;
        run_d       = 9'd0;
        converged_d = 1'b0;
        report_d    = 1'b0;
        rep_lat_d   = 8'd0;
        rep_to_d    = 1'b0;
        sum_ext_d   = 17'd0;
        lat_sum_d   = 16'd0;

        // Nothing counts as a transition until the first enabled sample has
        // captured a reference value.
        event_d = primed_q & en_i & (stim_in_i != stim_q);

        cnt_d = cnt_q + 8'd1;
        // Nine bits so a run can never wrap back under HOLD.
        run_d = (err_in_i <= TOL) ? ({1'b0, run_q} + 9'd1) : 9'd0;
        converged_d = (run_d >= HOLD_EFF);

        // Convergence wins over a timeout landing on the same sample.
        report_d  = converged_d | (cnt_d >= MAX_CYC);
        rep_lat_d = converged_d ? cnt_d : MAX_CYC;
        rep_to_d  = ~converged_d;

        sum_ext_d = {9'd0, rep_lat_d} + {1'b0, lat_sum_q};
        lat_sum_d = sum_ext_d[16] ? 16'hFFFF : sum_ext_d[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            stim_q        <= 8'd0;
            primed_q      <= 1'b0;
            cnt_q         <= 8'd0;
            run_q         <= 8'd0;
            busy_q        <= 1'b0;
            lat_valid_q   <= 1'b0;
            lat_out_q     <= 8'd0;
            lat_timeout_q <= 1'b0;
            trans_cnt_q   <= 8'd0;
            abort_cnt_q   <= 8'd0;
            lat_sum_q     <= 16'd0;
            lat_min_q     <= 8'hFF;
            lat_max_q     <= 8'd0;
        end else begin
            // The reference stimulus follows the input even while disabled,
            // so re-enabling never reports a stale change.
            stim_q <= stim_in_i;
            if (en_i) begin
                primed_q <= 1'b1;
            end
            lat_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (event_d) begin
                        state_q <= S_MEASURE;
                        cnt_q   <= 8'd0;
                        run_q   <= 8'd0;
                        busy_q  <= 1'b1;
                    end
                end

                S_MEASURE: begin
                    if (!en_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (event_d) begin
                        // A new transition restarts the count; a gamma pulse on
                        // the same edge belongs to the new stimulus' timeline
                        // and is deliberately not counted.
                        cnt_q <= 8'd0;
                        run_q <= 8'd0;
                        if (abort_cnt_q != 8'hFF) begin
                            abort_cnt_q <= abort_cnt_q + 8'd1;
                        end
                    end else if (cycle_start_i) begin
                        cnt_q <= cnt_d;
                        run_q <= run_d[7:0];
                        if (report_d) begin
                            // Results and statistics land on the edge into
                            // REPORT so they are stable while lat_valid is high.
                            state_q       <= S_REPORT;
                            lat_valid_q   <= 1'b1;
                            lat_out_q     <= rep_lat_d;
                            lat_timeout_q <= rep_to_d;
                            lat_sum_q     <= lat_sum_d;
                            if (trans_cnt_q != 8'hFF) begin
                                trans_cnt_q <= trans_cnt_q + 8'd1;
                            end
                            if (rep_lat_d < lat_min_q) begin
                                lat_min_q <= rep_lat_d;
                            end
                            if (rep_lat_d > lat_max_q) begin
                                lat_max_q <= rep_lat_d;
                            end
                        end
                    end
                end

                S_REPORT: begin
                    if (event_d) begin
                        state_q <= S_MEASURE;
                        cnt_q   <= 8'd0;
                        run_q   <= 8'd0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign lat_valid_o   = lat_valid_q;
    assign lat_out_o     = lat_out_q;
    assign lat_timeout_o = lat_timeout_q;
    assign trans_cnt_o   = trans_cnt_q;
    assign abort_cnt_o   = abort_cnt_q;
    assign lat_sum_o     = lat_sum_q;
    assign lat_min_o     = lat_min_q;
    assign lat_max_o     = lat_max_q;

endmodule

// File: tb/tb_conv_latency_monitor.sv
// tb/tb_conv_latency_monitor.sv - directed self-checking bench for conv_latency_monitor
module tb_conv_latency_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs  = 1'b0;
    logic       en  = 1'b1;
    logic [7:0] stim = 8'd0;
    logic [7:0] err  = 8'd0;

    always #5 clk = ~clk;

    // u_dut: TOL=5 HOLD=1 MAX=10, u_h2: HOLD=2, u_sat: MAX=255
    logic        d_busy, d_lv, d_to;
    logic [7:0]  d_lo, d_tr, d_ab, d_mn, d_mx;
    logic [15:0] d_sum;
    logic        h_busy, h_lv, h_to;
    logic [7:0]  h_lo, h_tr, h_ab, h_mn, h_mx;
    logic [15:0] h_sum;
    logic        s_busy, s_lv, s_to;
    logic [7:0]  s_lo, s_tr, s_ab, s_mn, s_mx;
    logic [15:0] s_sum;

    conv_latency_monitor u_dut (
        .clk_i(clk), .rst_i(rst), .cycle_start_i(cs), .en_i(en),
        .stim_in_i(stim), .err_in_i(err),
        .busy_o(d_busy), .lat_valid_o(d_lv), .lat_out_o(d_lo), .lat_timeout_o(d_to),
        .trans_cnt_o(d_tr), .abort_cnt_o(d_ab), .lat_sum_o(d_sum),
        .lat_min_o(d_mn), .lat_max_o(d_mx)
    );

    conv_latency_monitor #(.TOL(8'd5), .HOLD(8'd2), .MAX_CYC(8'd10)) u_h2 (
        .clk_i(clk), .rst_i(rst), .cycle_start_i(cs), .en_i(en),
        .stim_in_i(stim), .err_in_i(err),
        .busy_o(h_busy), .lat_valid_o(h_lv), .lat_out_o(h_lo), .lat_timeout_o(h_to),
        .trans_cnt_o(h_tr), .abort_cnt_o(h_ab), .lat_sum_o(h_sum),
        .lat_min_o(h_mn), .lat_max_o(h_mx)
    );

    conv_latency_monitor #(.TOL(8'd5), .HOLD(8'd1), .MAX_CYC(8'd255)) u_sat (
        .clk_i(clk), .rst_i(rst), .cycle_start_i(cs), .en_i(en),
        .stim_in_i(stim), .err_in_i(err),
        .busy_o(s_busy), .lat_valid_o(s_lv), .lat_out_o(s_lo), .lat_timeout_o(s_to),
        .trans_cnt_o(s_tr), .abort_cnt_o(s_ab), .lat_sum_o(s_sum),
        .lat_min_o(s_mn), .lat_max_o(s_mx)
    );

    typedef struct {
        logic [7:0]  stim;
        logic [7:0]  err;
        logic        cs;
        logic        en;
        logic        busy;
        logic        lv;
        logic [7:0]  lo;
        logic        to;
        logic [7:0]  tr;
        logic [7:0]  ab;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [15:0] sum;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cs  = 1'b0;
        en  = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] d_all();
        return {5'd0, d_busy, d_lv, d_lo, d_to, d_tr, d_ab, d_mn, d_mx, d_sum};
    endfunction

    function automatic logic [63:0] s_all();
        return {5'd0, s_busy, s_lv, s_lo, s_to, s_tr, s_ab, s_mn, s_mx, s_sum};
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t v);
        return {5'd0, v.busy, v.lv, v.lo, v.to, v.tr, v.ab, v.mn, v.mx, v.sum};
    endfunction

    int pulses;

    initial begin
        //          stim    err    cs    en   busy  lv   lo     to    tr     ab     mn      mx     sum
        vecs[0]  = '{8'd200, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 8'hFF, 8'd0, 16'd0};
        vecs[1]  = '{8'd200, 8'd40, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 8'hFF, 8'd0, 16'd0};
        vecs[2]  = '{8'd5,   8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 8'hFF, 8'd0, 16'd0};
        vecs[3]  = '{8'd5,   8'd40, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 8'hFF, 8'd0, 16'd0};
        vecs[4]  = '{8'd5,   8'd3,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 8'hFF, 8'd0, 16'd0};
        vecs[5]  = '{8'd5,   8'd20, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 8'hFF, 8'd0, 16'd0};
        vecs[6]  = '{8'd5,   8'd4,  1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 8'd1, 8'd0, 8'd3,  8'd3, 16'd3};
        vecs[7]  = '{8'd5,   8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 8'd1, 8'd0, 8'd3,  8'd3, 16'd3};
        vecs[8]  = '{8'd100, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 8'd1, 8'd0, 8'd3,  8'd3, 16'd3};
        vecs[9]  = '{8'd100, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 8'd1, 8'd0, 8'd3,  8'd3, 16'd3};
        vecs[10] = '{8'd100, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 8'd1, 8'd0, 8'd3,  8'd3, 16'd3};
        vecs[11] = '{8'd50,  8'd0,  1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 8'd1, 8'd1, 8'd3,  8'd3, 16'd3};
        vecs[12] = '{8'd50,  8'd6,  1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 8'd1, 8'd1, 8'd3,  8'd3, 16'd3};
        vecs[13] = '{8'd50,  8'd5,  1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 8'd2, 8'd1, 8'd2,  8'd3, 16'd5};
        vecs[14] = '{8'd60,  8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 8'd2, 8'd1, 8'd2,  8'd3, 16'd5};
        vecs[15] = '{8'd60,  8'd5,  1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 8'd3, 8'd1, 8'd1,  8'd3, 16'd6};
        vecs[16] = '{8'd60,  8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'd3, 8'd1, 8'd1,  8'd3, 16'd6};
        vecs[17] = '{8'd70,  8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 8'd3, 8'd1, 8'd1,  8'd3, 16'd6};
        vecs[18] = '{8'd70,  8'd50, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 8'd3, 8'd1, 8'd1,  8'd3, 16'd6};
        vecs[19] = '{8'd70,  8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'd3, 8'd1, 8'd1,  8'd3, 16'd6};
        vecs[20] = '{8'd80,  8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'd3, 8'd1, 8'd1,  8'd3, 16'd6};
        vecs[21] = '{8'd80,  8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'd3, 8'd1, 8'd1,  8'd3, 16'd6};
        vecs[22] = '{8'd80,  8'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'd3, 8'd1, 8'd1,  8'd3, 16'd6};

        // T1: reset state
        stim = 8'd200;
        err  = 8'd0;
        do_reset();
        check("reset_state", d_all(), {5'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 8'hFF, 8'd0, 16'd0});

        // T2 / T5 / enable handling, one row per clock
        for (int i = 0; i < NVEC; i++) begin
            stim = vecs[i].stim;
            err  = vecs[i].err;
            cs   = vecs[i].cs;
            en   = vecs[i].en;
            step();
            check($sformatf("vec[%0d]", i), d_all(), pack_exp(vecs[i]));
        end

        // T3: timeout after MAX_CYC=10 non-converged samples
        stim = 8'd90; cs = 1'b0; en = 1'b1; err = 8'd30;
        step();
        cs = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 9) begin
                check("timeout_pre", {62'd0, d_busy, d_lv}, {62'd0, 1'b1, 1'b0});
            end
        end
        check("timeout_report", {19'd0, d_lv, d_lo, d_to, d_tr, d_ab, d_mn, d_mx},
              {19'd0, 1'b1, 8'd10, 1'b1, 8'd4, 8'd1, 8'd1, 8'd10});
        check("timeout_sum", {48'd0, d_sum}, {48'd0, 16'd16});
        cs = 1'b0;
        step();
        check("timeout_idle", {62'd0, d_busy, d_lv}, 64'd0);

        // T4: HOLD=2, run broken by the second sample
        do_reset();
        stim = 8'd90;
        step();
        stim = 8'd91;
        step();
        check("hold2_busy", {63'd0, h_busy}, 64'd1);
        cs = 1'b1;
        err = 8'd3; step();
        err = 8'd9; step();
        err = 8'd2; step();
        check("hold2_pre", {62'd0, h_busy, h_lv}, {62'd0, 1'b1, 1'b0});
        err = 8'd4; step();
        check("hold2_report", {46'd0, h_lv, h_lo, h_to, h_tr}, {46'd0, 1'b1, 8'd4, 1'b0, 8'd1});
        cs = 1'b0;
        step();

        // T6: saturation with 255-cycle timeouts
        do_reset();
        stim = 8'd1;
        err  = 8'd30;
        step();
        pulses = 0;
        for (int k = 0; k < 270; k++) begin
            stim = stim + 8'd1;
            cs = 1'b0;
            step();
            cs = 1'b1;
            for (int j = 0; j < 255; j++) begin
                step();
            end
            if (s_lv) pulses++;
            if (k == 254) begin
                check("sat_at_255", {40'd0, s_tr, s_sum}, {40'd0, 8'd255, 16'd65025});
            end
            cs = 1'b0;
            step();
        end
        check("sat_pulses", 64'(pulses), 64'd270);
        check("sat_final", {23'd0, s_lo, s_to, s_tr, s_ab, s_sum},
              {23'd0, 8'd255, 1'b1, 8'd255, 8'd0, 16'hFFFF});
        check("sat_minmax", {48'd0, s_mn, s_mx}, {48'd0, 8'd255, 8'd255});

        // rst asserted mid-measurement
        stim = stim + 8'd1;
        cs = 1'b0;
        step();
        cs = 1'b1;
        step(); step(); step();
        check("mid_busy", {63'd0, s_busy}, 64'd1);
        rst = 1'b1;
        step();
        check("mid_reset", s_all(), {5'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 8'hFF, 8'd0, 16'd0});
        rst = 1'b0;
        cs = 1'b0;
        stim = 8'd77;
        step();
        check("reprime_no_event", {63'd0, s_busy}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
